// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : arb_pkg
//  Brief    : Shared constants, state type and arbitration helpers for the
//             four-way one-hot round-robin arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package arb_pkg;

   localparam int N_REQ = 4;
   localparam int IDX_W = 2;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   // Scan start, start+1, ... (mod N_REQ) over req with excluded bits masked;
   // return the first hit as a one-hot vector, or zero when nobody qualifies.
   // Iterating from the far end lets the nearest candidate overwrite the rest.
   function automatic logic [N_REQ-1:0] next_winner(
      input logic [N_REQ-1:0] req,
      input logic [IDX_W-1:0] start,
      input logic [N_REQ-1:0] exclude_mask
   );
      logic [N_REQ-1:0] cand;
      logic [IDX_W-1:0] pos;
      next_winner = '0;
      cand        = req & ~exclude_mask;
      for (int k = N_REQ-1; k >= 0; k--) begin
         pos = start + IDX_W'(k);
         if (cand[pos]) begin
            next_winner      = '0;
            next_winner[pos] = 1'b1;
         end
      end
   endfunction

   // OR-tree one-hot to binary: each index bit depends only on grant bits,
   // so it switches exactly when the grant vector does. Zero maps to 0.
   function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] v);
      onehot_to_idx = {v[3] | v[2], v[3] | v[1]};
   endfunction

endpackage
`default_nettype wire

// File: rtl/onehot_enc4.sv
`default_nettype none
// ============================================================================
//  Module   : onehot_enc4
//  Brief    : Combinational 4-bit one-hot to binary encoder with an
//             illegal-pattern (multi-hot) indicator.
//  Revision : 1.0 - initial release
// ============================================================================
module onehot_enc4
   import arb_pkg::*;
(
   input  logic [N_REQ-1:0] onehot,
   output logic [IDX_W-1:0] idx,
   output logic             bad
);

   // Index decode plus multi-hot detect: clearing the lowest set bit leaves
   // something behind only when more than one bit was set.
   always_comb begin
      idx = onehot_to_idx(onehot);
      bad = (onehot != '0) && ((onehot & (onehot - 4'd1)) != '0);
   end

endmodule
`default_nettype wire

// File: rtl/onehot_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : onehot_rr_arbiter
//  Brief    : Four-requester round-robin arbiter with registered one-hot
//             grant, binary owner index, tenure limit and sticky error flag.
//  Revision : 1.0 - initial release
// ============================================================================
module onehot_rr_arbiter
   import arb_pkg::*;
#(
   parameter int MAX_HOLD = 16
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_valid,
   output logic             err
);

   localparam int                CNT_W     = $clog2(MAX_HOLD);
   localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(MAX_HOLD - 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [N_REQ-1:0]   r_gnt;
   logic [N_REQ-1:0]   w_gnt_nxt;
   logic [IDX_W-1:0]   r_ptr;
   logic [IDX_W-1:0]   w_ptr_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic               r_err;

   logic [N_REQ-1:0]   w_win;
   logic [N_REQ-1:0]   w_others;
   logic [IDX_W-1:0]   w_idx;
   logic               w_bad;

   // Owner index and legality are always derived from the registered grant.
   onehot_enc4 u_enc (
      .onehot (r_gnt),
      .idx    (w_idx),
      .bad    (w_bad)
   );

   // Next-state logic: arbitrate from idle, or hold / hand over / rotate.
   always_comb begin
      w_state_nxt = r_state;
      w_gnt_nxt   = r_gnt;
      w_ptr_nxt   = r_ptr;
      w_cnt_nxt   = r_cnt;
      w_win       = '0;
      w_others    = req & ~r_gnt;

      case (r_state)
         ST_IDLE: begin
            w_win = next_winner(req, r_ptr, '0);
            if (w_win != '0) begin
               w_state_nxt = ST_GRANT;
               w_gnt_nxt   = w_win;
               w_ptr_nxt   = onehot_to_idx(w_win) + 2'd1;
               w_cnt_nxt   = '0;
            end
         end

         ST_GRANT: begin
            if (((req & r_gnt) != '0) && ((r_cnt != C_CNT_MAX) || (w_others == '0))) begin
               // Hold: tenure counter saturates so a lone owner never wraps.
               if (r_cnt != C_CNT_MAX) begin
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end else begin
               // Release or forced rotation: the owner is excluded either
               // way, so one scan from owner+1 covers both cases.
               w_win = next_winner(req, w_idx + 2'd1, r_gnt);
               if (w_win != '0) begin
                  w_gnt_nxt = w_win;
                  w_ptr_nxt = onehot_to_idx(w_win) + 2'd1;
                  w_cnt_nxt = '0;
               end else begin
                  w_state_nxt = ST_IDLE;
                  w_gnt_nxt   = '0;
                  w_cnt_nxt   = '0;
               end
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
            w_gnt_nxt   = '0;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // State registers; the error flag latches any illegal grant pattern.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_gnt   <= '0;
         r_ptr   <= '0;
         r_cnt   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_gnt   <= w_gnt_nxt;
         r_ptr   <= w_ptr_nxt;
         r_cnt   <= w_cnt_nxt;
         r_err   <= r_err | w_bad;
      end
   end

   assign gnt       = r_gnt;
   assign gnt_idx   = w_idx;
   assign gnt_valid = |r_gnt;
   assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_onehot_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_onehot_rr_arbiter
//  Brief    : Self-checking bench for onehot_rr_arbiter: directed scenarios
//             with literal expectations plus a cycle-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_onehot_rr_arbiter;

   localparam int MH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = 4'b0000;
   logic [3:0] gnt;
   logic [1:0] gnt_idx;
   logic       gnt_valid;
   logic       err;

   int n_vec = 0;
   int n_err = 0;

   onehot_rr_arbiter #(.MAX_HOLD(MH)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid),
      .err       (err)
   );

   always #5 clk = ~clk;

   // Reference model: owner as an integer (-1 = nobody), pointer and tenure.
   int m_owner   = -1;
   int m_ptr     = 0;
   int m_cnt     = 0;
   bit m_started = 1'b0;

   function automatic int pick(input logic [3:0] r, input int start, input int excl);
      for (int k = 0; k < 4; k++) begin
         int j;
         j = (start + k) % 4;
         if (j != excl && r[j]) return j;
      end
      return -1;
   endfunction

   // Model update at each rising edge, from the same req the DUT samples.
   always @(posedge clk) begin
      int w;
      if (rst) begin
         m_owner   = -1;
         m_ptr     = 0;
         m_cnt     = 0;
         m_started = 1'b1;
      end else if (m_owner < 0) begin
         w = pick(req, m_ptr, -1);
         if (w >= 0) begin
            m_owner = w; m_ptr = (w + 1) % 4; m_cnt = 0;
         end
      end else if (req[m_owner] && (m_cnt < MH-1 || (req & ~(4'b0001 << m_owner)) == 4'b0000)) begin
         if (m_cnt < MH-1) m_cnt = m_cnt + 1;
      end else begin
         w = pick(req, (m_owner + 1) % 4, m_owner);
         if (w >= 0) begin
            m_owner = w; m_ptr = (w + 1) % 4; m_cnt = 0;
         end else begin
            m_owner = -1; m_cnt = 0;
         end
      end
   end

   // Per-cycle comparison against the model, plus starvation bound.
   int wt [4] = '{0, 0, 0, 0};
   always @(negedge clk) begin
      logic [3:0] e_gnt;
      logic [1:0] e_idx;
      bit         starve;
      if (m_started) begin
         e_gnt  = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
         e_idx  = (m_owner < 0) ? 2'd0 : 2'(m_owner);
         starve = 1'b0;
         for (int i = 0; i < 4; i++) begin
            if (req[i] && !gnt[i]) wt[i] = wt[i] + 1;
            else                   wt[i] = 0;
            if (wt[i] > 3*MH+1) starve = 1'b1;
         end
         n_vec++;
         if (gnt !== e_gnt || gnt_idx !== e_idx || gnt_valid !== (m_owner >= 0) ||
             err !== 1'b0 || starve) begin
            n_err++;
            $display("FAIL model t=%0t: gnt=%b idx=%0d valid=%b err=%b starve=%0b, required gnt=%b idx=%0d valid=%b err=0",
                     $time, gnt, gnt_idx, gnt_valid, err, starve, e_gnt, e_idx, (m_owner >= 0));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b, required %b", name, act, exp);
      end
   endtask

   initial begin
      // Reset state
      rst = 1'b1; req = 4'b0000;
      tick(); tick();
      chk("reset_gnt",   gnt, 4'b0000);
      chk("reset_idx",   {2'b00, gnt_idx}, 4'b0000);
      chk("reset_valid", {3'b000, gnt_valid}, 4'b0000);
      chk("reset_err",   {3'b000, err}, 4'b0000);
      rst = 1'b0;

      // Basic grant, then release handover with no bubble, then idle
      req = 4'b0101; tick();
      chk("basic_gnt",   gnt, 4'b0001);
      chk("basic_idx",   {2'b00, gnt_idx}, 4'b0000);
      chk("basic_valid", {3'b000, gnt_valid}, 4'b0001);
      req = 4'b0100; tick();
      chk("handover_gnt", gnt, 4'b0100);
      chk("handover_idx", {2'b00, gnt_idx}, 4'b0010);
      req = 4'b0000; tick();
      chk("idle_gnt",   gnt, 4'b0000);
      chk("idle_valid", {3'b000, gnt_valid}, 4'b0000);

      // Forced rotation with all four requesting, from ptr=0
      rst = 1'b1; tick(); rst = 1'b0;
      req = 4'b1111;
      for (int k = 0; k < 17; k++) begin
         tick();
         chk($sformatf("rotate_%0d", k), gnt, 4'b0001 << ((k / MH) % 4));
      end

      // Lone requester keeps the grant past MAX_HOLD, then rotates away
      req = 4'b0010; tick();
      chk("lone_first", gnt, 4'b0010);
      for (int k = 0; k < 3*MH; k++) begin
         tick();
         chk($sformatf("lone_hold_%0d", k), gnt, 4'b0010);
      end
      req = 4'b1010; tick();
      chk("lone_rotate", gnt, 4'b1000);
      chk("lone_rotate_idx", {2'b00, gnt_idx}, 4'b0011);

      // Mid-grant reset restarts the scan from requester 0
      req = 4'b0100; tick();
      chk("pre_reset_gnt", gnt, 4'b0100);
      rst = 1'b1; tick();
      chk("mid_reset_gnt", gnt, 4'b0000);
      rst = 1'b0; req = 4'b1001; tick();
      chk("post_reset_gnt", gnt, 4'b0001);

      // Random stress, each bit requested with probability 6/16
      for (int c = 0; c < 20000; c++) begin
         logic [3:0] r;
         for (int b = 0; b < 4; b++) r[b] = ($urandom_range(0, 15) < 6);
         req = r;
         tick();
      end
      req = 4'b0000;
      tick(); tick();
      chk("final_err", {3'b000, err}, 4'b0000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
